// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, LSB-first data, optional parity, 1-2 stop bits.
// One word per valid/ready handshake; every output is registered.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  generate
    if (CLKS_PER_BIT < 2 || DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
      $error("uart_tx_cfg: illegal parameter combination");
    end
  endgenerate

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST  = IDX_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // ready_q is low for one cycle after reset, so a held tx_valid waits for it.
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          par_d   = (PARITY == 2) ? ~^tx_data : ^tx_data;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (idx_q == IDX_DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    // Line level is derived from the next state so tx changes on the same edge as the state.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign busy     = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: five instances cover basic, even/odd parity,
// two stop bits with back-to-back frames, and a 9-bit word. All use 4 clocks per bit.
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] valid;
  logic [7:0] data8 [4];
  logic [8:0] data9;
  logic [4:0] tx_w, ready_w, busy_w, done_w;

  int n_assert;
  int n_fail;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_basic (
    .clk(clk), .rst_n(rst_n), .tx_data(data8[0]), .tx_valid(valid[0]),
    .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(data8[1]), .tx_valid(valid[1]),
    .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(data8[2]), .tx_valid(valid[2]),
    .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data8[3]), .tx_valid(valid[3]),
    .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .tx_done(done_w[3]));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_W(9), .PARITY(2), .STOP_BITS(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .tx_data(data9), .tx_valid(valid[4]),
    .tx_ready(ready_w[4]), .tx(tx_w[4]), .busy(busy_w[4]), .tx_done(done_w[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered just after the handshake edge; seq[i] is the line level of bit slot i.
  // Returns just after the edge that ends the frame (the tx_done cycle).
  task automatic check_frame(input int u, input logic [15:0] seq, input int nbits,
                             input bit pulse, input string tag);
    for (int k = 0; k < nbits * CPB; k++) begin
      chk($sformatf("%s tx cyc%0d", tag, k), {15'b0, tx_w[u]}, {15'b0, seq[k / CPB]});
      chk($sformatf("%s done cyc%0d", tag, k), {15'b0, done_w[u]}, 16'd0);
      if (k == 0) begin
        chk({tag, " busy_start"}, {15'b0, busy_w[u]}, 16'd1);
        chk({tag, " ready_start"}, {15'b0, ready_w[u]}, 16'd0);
      end
      if (pulse && k == 20) valid[u] = 1'b1;
      if (pulse && k == 21) valid[u] = 1'b0;
      tick();
    end
    chk({tag, " done_end"}, {15'b0, done_w[u]}, 16'd1);
    chk({tag, " ready_end"}, {15'b0, ready_w[u]}, 16'd1);
    chk({tag, " busy_end"}, {15'b0, busy_w[u]}, 16'd0);
    chk({tag, " tx_end"}, {15'b0, tx_w[u]}, 16'd1);
    $display("frame %s on unit %0d: %0d bits checked", tag, u, nbits);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    valid    = '0;
    for (int i = 0; i < 4; i++) data8[i] = 8'h00;
    data9    = 9'h000;

    // Reset held with a pending word
    valid[0] = 1'b1;
    data8[0] = 8'h5A;
    repeat (5) tick();
    chk("rst tx", {15'b0, tx_w[0]}, 16'd1);
    chk("rst ready", {15'b0, ready_w[0]}, 16'd0);
    chk("rst busy", {15'b0, busy_w[0]}, 16'd0);
    chk("rst done", {15'b0, done_w[0]}, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("release ready", {15'b0, ready_w[0]}, 16'd1);
    chk("release busy", {15'b0, busy_w[0]}, 16'd0);
    chk("release tx", {15'b0, tx_w[0]}, 16'd1);
    tick();
    valid[0] = 1'b0;
    data8[0] = 8'hFF;
    check_frame(0, 16'b10_1011_0100, 10, 1'b0, "rst_5A");
    tick();
    chk("rst_5A done_gone", {15'b0, done_w[0]}, 16'd0);

    // Basic 0xA5 frame
    valid[0] = 1'b1;
    data8[0] = 8'hA5;
    tick();
    valid[0] = 1'b0;
    check_frame(0, 16'b11_0100_1010, 10, 1'b0, "basic_A5");
    tick();
    chk("basic done_gone", {15'b0, done_w[0]}, 16'd0);

    // Even and odd parity on 0x07
    valid[1] = 1'b1;
    data8[1] = 8'h07;
    tick();
    valid[1] = 1'b0;
    check_frame(1, 16'b110_0000_1110, 11, 1'b0, "even_07");
    tick();
    valid[2] = 1'b1;
    data8[2] = 8'h07;
    tick();
    valid[2] = 1'b0;
    check_frame(2, 16'b100_0000_1110, 11, 1'b0, "odd_07");
    tick();

    // Back-to-back with two stop bits, tx_valid held across frames
    valid[3] = 1'b1;
    data8[3] = 8'h00;
    tick();
    data8[3] = 8'hFF;
    check_frame(3, 16'b110_0000_0000, 11, 1'b0, "b2b_00");
    tick();
    valid[3] = 1'b0;
    check_frame(3, 16'b111_1111_1110, 11, 1'b0, "b2b_FF");
    tick();
    chk("b2b done_gone", {15'b0, done_w[3]}, 16'd0);
    chk("b2b idle busy", {15'b0, busy_w[3]}, 16'd0);

    // Abort in the third data bit of 0x00
    valid[0] = 1'b1;
    data8[0] = 8'h00;
    tick();
    valid[0] = 1'b0;
    repeat (13) tick();
    chk("abort pre tx", {15'b0, tx_w[0]}, 16'd0);
    chk("abort pre busy", {15'b0, busy_w[0]}, 16'd1);
    rst_n = 1'b0;
    tick();
    chk("abort tx", {15'b0, tx_w[0]}, 16'd1);
    chk("abort busy", {15'b0, busy_w[0]}, 16'd0);
    chk("abort ready", {15'b0, ready_w[0]}, 16'd0);
    chk("abort done", {15'b0, done_w[0]}, 16'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      chk($sformatf("abort quiet done cyc%0d", k), {15'b0, done_w[0]}, 16'd0);
      chk($sformatf("abort quiet tx cyc%0d", k), {15'b0, tx_w[0]}, 16'd1);
    end
    valid[0] = 1'b1;
    data8[0] = 8'h3C;
    tick();
    valid[0] = 1'b0;
    check_frame(0, 16'b10_0111_1000, 10, 1'b0, "after_abort_3C");
    tick();

    // Nine-bit word with odd parity; a mid-frame tx_valid pulse must be ignored
    valid[4] = 1'b1;
    data9    = 9'h1FF;
    tick();
    valid[4] = 1'b0;
    data9    = 9'h000;
    check_frame(4, 16'b1011_1111_1110, 12, 1'b1, "wide_1FF");
    tick();
    chk("wide idle busy", {15'b0, busy_w[4]}, 16'd0);
    chk("wide idle done", {15'b0, done_w[4]}, 16'd0);
    chk("wide idle tx", {15'b0, tx_w[4]}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised UART transmitter that serialises one parallel word per valid/ready handshake into a standard asynchronous frame: start bit, LSB-first data, optional parity, and one or two stop bits. It generalises the common UART state set (IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT) with compile-time data width, parity mode, stop-bit count and an internal baud divider. It sits between a byte/word source (FIFO or register interface) and the serial pin.

## Interface
- CLKS_PER_BIT, default 868: clk cycles per serial bit (100 MHz / 115200); legal ≥ 2.
- DATA_W, default 8: data bits per frame; legal 5..9.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, default 1: legal 1 or 2.
- Illegal parameter values cause an elaboration error.

- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- tx_data  input  DATA_W  word to send; sampled only on handshake.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  block can accept a word (high only in IDLE).
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high from the START_BIT through the last STOP_BIT cycle.
- tx_done  output  1  one-cycle pulse after a frame completes.

## Operation
- One clock, one reset. Reset is synchronous and active-low.
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT.
- The bit counter (clog2(CLKS_PER_BIT) wide) counts 0..CLKS_PER_BIT-1 in each bit state. The index counter tracks data bit or stop bit number.
- IDLE: tx = 1, tx_ready = 1. If tx_valid && tx_ready at an edge, latch tx_data into the shift register, compute parity, and go to START_BIT.
- START_BIT: tx = 0 for CLKS_PER_BIT cycles, then go to DATA_BITS.
- DATA_BITS: tx = shift_reg[0]. At each bit end, shift right. After DATA_W bits, go to PARITY_BIT if PARITY != 0, else STOP_BIT.
- PARITY_BIT: tx = ^data for even parity, ~^data for odd parity, where data is the latched word. Lasts CLKS_PER_BIT cycles.
- STOP_BIT: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done.
- tx_valid outside IDLE is ignored; no word is accepted. Changes to tx_data after acceptance do not affect the frame in flight.
- Any unused state encoding returns to IDLE with tx = 1.

## Timing
- During reset (rst_n low at an edge), after that edge:
  - tx = 1, tx_ready = 0, busy = 0, tx_done = 0.
  - State = IDLE and counters = 0.
- In the first cycle after release, tx_ready = 1.
- Reset mid-frame aborts the frame: tx = 1 from the next edge, no tx_done, and the word is lost.
- Handshake at edge E0: from E0, tx = 0, busy = 1, tx_ready = 0. The start bit spans E0 through E0 + CLKS_PER_BIT.
- Frame length F = CLKS_PER_BIT × (1 + DATA_W + (PARITY != 0) + STOP_BITS) cycles. The state returns to IDLE at E0 + F.
- tx_done is high for exactly the cycle following E0 + F. In that same cycle tx_ready = 1 and busy = 0.
- Back-to-back frames: with tx_valid held, the next word is accepted at E0 + F + 1. Minimum idle gap between frames is 1 clk cycle (tx = 1).
- Bit boundaries are exact: no drift; each bit is exactly CLKS_PER_BIT cycles.

## Test plan
- **Reset:** hold rst_n = 0 for 5 cycles with tx_valid = 1. Required: tx = 1, tx_ready = 0, no acceptance. Release: tx_ready = 1 next cycle, then the word is accepted.
- **Basic frame:** DATA_W = 8, PARITY = 0, STOP_BITS = 1, CLKS_PER_BIT = 4; send 0xA5. Required: line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; F = 40; tx_done one cycle at E0 + 41.
- **Parity:** CLKS_PER_BIT = 4; send 0x07.
  - PARITY = 1 (even): parity bit = 1.
  - PARITY = 2 (odd): parity bit = 0.
  - F = 44 in both cases.
- **Back-to-back:** STOP_BITS = 2; send 0x00 then 0xFF with tx_valid held. Required:
  - Stop-bit phase of 8 cycles high.
  - Second handshake exactly 1 cycle after the first frame ends, coincident with tx_done.
  - The second frame's data bits are all 1.
- **Abort:** reset during the 3rd data bit. Required: tx = 1 at the next edge, no tx_done. A subsequent 0x3C frame is correct.
- **Wide word:** DATA_W = 9, PARITY = 2 (odd); send 0x1FF. Required: nine 1 data bits and parity bit = 0; while busy, tx_valid pulses are ignored.
